// File: rtl/dcache_port_arbiter.sv
// Purpose: single-port arbiter between store-buffer drain and LSU loads in front of the dcache (build option: STB_LOAD_ORDER_EN).
// Latency: request sampled in IDLE drives arb2dcache_req the next cycle; source ack is combinational with dcache2arb_ack.
// Backpressure: granted request is latched and held until dcache2arb_ack; the losing source simply keeps its req asserted.
module dcache_port_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int BYTE_SEL_WIDTH = 4,
    parameter int STARVE_MAX     = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    // store buffer drain path
    input  logic [ADDR_WIDTH-1:0]     stb2dcache_addr,
    input  logic [DATA_WIDTH-1:0]     stb2dcache_wdata,
    input  logic [BYTE_SEL_WIDTH-1:0] stb2dcache_sel_byte,
    input  logic                      stb2dcache_w_en,
    input  logic                      stb2dcache_req,
    input  logic                      stb2dcache_empty,
    output logic                      dcache2stb_ack,
    // LSU load path
    input  logic [ADDR_WIDTH-1:0]     lsudbus2arb_addr,
    input  logic                      lsudbus2arb_req,
    output logic                      arb2lsudbus_ack,
    output logic [DATA_WIDTH-1:0]     arb2lsudbus_rdata,
    // dcache port
    output logic [ADDR_WIDTH-1:0]     arb2dcache_addr,
    output logic [DATA_WIDTH-1:0]     arb2dcache_wdata,
    output logic [BYTE_SEL_WIDTH-1:0] arb2dcache_sel_byte,
    output logic                      arb2dcache_w_en,
    output logic                      arb2dcache_req,
    input  logic                      dcache2arb_ack,
    input  logic [DATA_WIDTH-1:0]     dcache2arb_rdata
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX_C = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_STORE = 2'd2
    } state_t;

    state_t                    state_q,      state_d;
    logic [CNT_W-1:0]          starve_cnt_q, starve_cnt_d;
    logic                      req_q,        req_d;
    logic                      w_en_q,       w_en_d;
    logic [ADDR_WIDTH-1:0]     addr_q,       addr_d;
    logic [DATA_WIDTH-1:0]     wdata_q,      wdata_d;
    logic [BYTE_SEL_WIDTH-1:0] sel_q,        sel_d;

    logic load_elig;
    logic grant_load;
    logic grant_store;

    // The store buffer always writes; its w_en carries no extra information.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, stb2dcache_w_en, stb2dcache_empty};

`ifdef STB_LOAD_ORDER_EN
    // Strict ordering: a load may only go once every older store has drained.
    assign load_elig = stb2dcache_empty & ~stb2dcache_req;
`else
    assign load_elig = 1'b1;
`endif

    // Grant decision in IDLE: loads win unless the store has been passed over STARVE_MAX times.
    always_comb begin
        grant_load  = 1'b0;
        grant_store = 1'b0;
        if (state_q == ST_IDLE) begin
            if (lsudbus2arb_req && load_elig && stb2dcache_req) begin
                if (starve_cnt_q == STARVE_MAX_C) begin
                    grant_store = 1'b1;
                end else begin
                    grant_load = 1'b1;
                end
            end else if (lsudbus2arb_req && load_elig) begin
                grant_load = 1'b1;
            end else if (stb2dcache_req) begin
                grant_store = 1'b1;
            end
        end
    end

    // Next-state: latch the winner on grant, hold it until the dcache acknowledges.
    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        req_d        = req_q;
        w_en_d       = w_en_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        sel_d        = sel_q;
        if (grant_load) begin
            state_d = ST_LOAD;
            req_d   = 1'b1;
            w_en_d  = 1'b0;
            addr_d  = lsudbus2arb_addr;
            wdata_d = '0;
            sel_d   = '1;
            // Only count loads that actually overtook a waiting store.
            if (stb2dcache_req && (starve_cnt_q != STARVE_MAX_C)) begin
                starve_cnt_d = starve_cnt_q + CNT_W'(1);
            end
        end else if (grant_store) begin
            state_d      = ST_STORE;
            req_d        = 1'b1;
            w_en_d       = 1'b1;
            addr_d       = stb2dcache_addr;
            wdata_d      = stb2dcache_wdata;
            sel_d        = stb2dcache_sel_byte;
            starve_cnt_d = '0;
        end else if ((state_q != ST_IDLE) && dcache2arb_ack) begin
            // Completion; an ack seen in IDLE never reaches this branch.
            state_d = ST_IDLE;
            req_d   = 1'b0;
        end
    end

    // State and registered dcache-side outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            starve_cnt_q <= '0;
            req_q        <= 1'b0;
            w_en_q       <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            sel_q        <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            req_q        <= req_d;
            w_en_q       <= w_en_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            sel_q        <= sel_d;
        end
    end

    assign arb2dcache_req      = req_q;
    assign arb2dcache_w_en     = w_en_q;
    assign arb2dcache_addr     = addr_q;
    assign arb2dcache_wdata    = wdata_q;
    assign arb2dcache_sel_byte = sel_q;

    // Route the dcache ack and read data back to whichever source owns the port.
    assign dcache2stb_ack    = dcache2arb_ack & (state_q == ST_STORE);
    assign arb2lsudbus_ack   = dcache2arb_ack & (state_q == ST_LOAD);
    assign arb2lsudbus_rdata = (state_q == ST_LOAD) ? dcache2arb_rdata : '0;

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Purpose: self-checking bench for dcache_port_arbiter with a transaction-level reference model.
// Latency: inputs change 1 time unit after posedge, outputs are checked on the negedge.
// Backpressure: bench sources hold req until their ack; the dcache responder acks after a chosen delay.
module tb_dcache_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int SMAX = 4;

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] stb2dcache_addr;
    logic [DW-1:0] stb2dcache_wdata;
    logic [SW-1:0] stb2dcache_sel_byte;
    logic          stb2dcache_w_en;
    logic          stb2dcache_req;
    logic          stb2dcache_empty;
    logic          dcache2stb_ack;
    logic [AW-1:0] lsudbus2arb_addr;
    logic          lsudbus2arb_req;
    logic          arb2lsudbus_ack;
    logic [DW-1:0] arb2lsudbus_rdata;
    logic [AW-1:0] arb2dcache_addr;
    logic [DW-1:0] arb2dcache_wdata;
    logic [SW-1:0] arb2dcache_sel_byte;
    logic          arb2dcache_w_en;
    logic          arb2dcache_req;
    logic          dcache2arb_ack;
    logic [DW-1:0] dcache2arb_rdata;

    dcache_port_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_SEL_WIDTH(SW), .STARVE_MAX(SMAX)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .stb2dcache_addr(stb2dcache_addr), .stb2dcache_wdata(stb2dcache_wdata),
        .stb2dcache_sel_byte(stb2dcache_sel_byte), .stb2dcache_w_en(stb2dcache_w_en),
        .stb2dcache_req(stb2dcache_req), .stb2dcache_empty(stb2dcache_empty),
        .dcache2stb_ack(dcache2stb_ack),
        .lsudbus2arb_addr(lsudbus2arb_addr), .lsudbus2arb_req(lsudbus2arb_req),
        .arb2lsudbus_ack(arb2lsudbus_ack), .arb2lsudbus_rdata(arb2lsudbus_rdata),
        .arb2dcache_addr(arb2dcache_addr), .arb2dcache_wdata(arb2dcache_wdata),
        .arb2dcache_sel_byte(arb2dcache_sel_byte), .arb2dcache_w_en(arb2dcache_w_en),
        .arb2dcache_req(arb2dcache_req), .dcache2arb_ack(dcache2arb_ack),
        .dcache2arb_rdata(dcache2arb_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: which transaction owns the port (0 none, 1 load, 2 store),
    // the fields it must present, and how many loads overtook a waiting store.
    int          m_owner;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [SW-1:0] m_sel;
    logic          m_we;
    int            m_starved;

    // Stimulus controls
    bit ld_cont, st_cont, ld_rand, st_rand, spur, rand_dly, rd_fix, spur_force;
    int dly, dly_cnt;

    // Observations
    int   grants[$];
    int   n_stb_ack, n_ld_ack;
    logic prev_req;
    bit   ld_ack_seen, st_ack_seen;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = 0; m_addr = '0; m_wdata = '0; m_sel = '0; m_we = 1'b0; m_starved = 0;
    endtask

    task automatic clear_logs();
        grants.delete();
        n_stb_ack = 0;
        n_ld_ack  = 0;
    endtask

    // One clock: check at negedge, advance model, then update stimulus after posedge.
    task automatic cycle();
        bit ld, st, elig;
        @(negedge clk);
        chk("req", arb2dcache_req, (m_owner != 0));
        if (m_owner != 0) begin
            chk("w_en",  arb2dcache_w_en,     m_we);
            chk("addr",  arb2dcache_addr,     m_addr);
            chk("wdata", arb2dcache_wdata,    m_wdata);
            chk("sel",   arb2dcache_sel_byte, m_sel);
        end
        chk("stb_ack", dcache2stb_ack,    dcache2arb_ack && (m_owner == 2));
        chk("ld_ack",  arb2lsudbus_ack,   dcache2arb_ack && (m_owner == 1));
        chk("rdata",   arb2lsudbus_rdata, (m_owner == 1) ? dcache2arb_rdata : '0);

        if (arb2dcache_req && !prev_req) grants.push_back(arb2dcache_w_en ? 1 : 0);
        prev_req    = arb2dcache_req;
        ld_ack_seen = arb2lsudbus_ack;
        st_ack_seen = dcache2stb_ack;
        n_ld_ack   += int'(arb2lsudbus_ack);
        n_stb_ack  += int'(dcache2stb_ack);

`ifdef STB_LOAD_ORDER_EN
        elig = stb2dcache_empty && !stb2dcache_req;
`else
        elig = 1'b1;
`endif
        ld = lsudbus2arb_req && elig;
        st = stb2dcache_req;
        if (m_owner == 0) begin
            if (st && (!ld || m_starved >= SMAX)) begin
                m_owner = 2; m_we = 1'b1; m_addr = stb2dcache_addr;
                m_wdata = stb2dcache_wdata; m_sel = stb2dcache_sel_byte; m_starved = 0;
            end else if (ld) begin
                m_owner = 1; m_we = 1'b0; m_addr = lsudbus2arb_addr;
                m_wdata = '0; m_sel = '1;
                if (st && m_starved < SMAX) m_starved++;
            end
        end else if (dcache2arb_ack) begin
            m_owner = 0;
        end

        @(posedge clk);
        #1;
        // LSU source
        if (ld_ack_seen) begin
            if (ld_cont) lsudbus2arb_addr = $urandom;
            else lsudbus2arb_req = 1'b0;
        end else if (!lsudbus2arb_req && ld_rand && ($urandom_range(0, 2) == 0)) begin
            lsudbus2arb_req  = 1'b1;
            lsudbus2arb_addr = $urandom;
        end
        // Store-buffer source
        if (st_ack_seen) begin
            if (st_cont) begin
                stb2dcache_addr = $urandom; stb2dcache_wdata = $urandom;
                stb2dcache_sel_byte = SW'($urandom);
            end else begin
                stb2dcache_req   = 1'b0;
                stb2dcache_empty = st_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
        end else if (!stb2dcache_req && st_rand && ($urandom_range(0, 2) == 0)) begin
            stb2dcache_req   = 1'b1;
            stb2dcache_empty = 1'b0;
            stb2dcache_addr  = $urandom; stb2dcache_wdata = $urandom;
            stb2dcache_sel_byte = SW'($urandom);
        end else if (!stb2dcache_req && st_rand) begin
            stb2dcache_empty = ($urandom_range(0, 3) != 0);
        end
        stb2dcache_w_en = stb2dcache_req;
        // dcache responder
        if (arb2dcache_req) begin
            dcache2arb_ack = (dly_cnt == dly);
            dly_cnt++;
        end else begin
            dly_cnt = 0;
            dcache2arb_ack = spur_force || (spur && ($urandom_range(0, 3) == 0));
            if (rand_dly) dly = $urandom_range(0, 3);
        end
        dcache2arb_rdata = rd_fix ? 32'h1234_5678 : $urandom;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req"},    arb2dcache_req, 1'b0);
        chk({tag, "_w_en"},   arb2dcache_w_en, 1'b0);
        chk({tag, "_addr"},   arb2dcache_addr, '0);
        chk({tag, "_wdata"},  arb2dcache_wdata, '0);
        chk({tag, "_sel"},    arb2dcache_sel_byte, '0);
        chk({tag, "_stbak"},  dcache2stb_ack, 1'b0);
        chk({tag, "_ldak"},   arb2lsudbus_ack, 1'b0);
        chk({tag, "_rdata"},  arb2lsudbus_rdata, '0);
    endtask

    initial begin
        int exp_g;
        int got_g;
        rst_n = 1'b0;
        stb2dcache_addr = '0; stb2dcache_wdata = '0; stb2dcache_sel_byte = '0;
        stb2dcache_w_en = 1'b0; stb2dcache_req = 1'b0; stb2dcache_empty = 1'b1;
        lsudbus2arb_addr = '0; lsudbus2arb_req = 1'b0;
        dcache2arb_ack = 1'b1; dcache2arb_rdata = 32'hFFFF_FFFF;
        {ld_cont, st_cont, ld_rand, st_rand, spur, rand_dly, rd_fix, spur_force} = '0;
        dly = 0; dly_cnt = 0; prev_req = 1'b0;
        model_reset();
        clear_logs();

        // Reset state, with a dcache ack present that must not leak through
        #12;
        chk_all_zero("reset");
        @(posedge clk); #1;
        dcache2arb_ack = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // Store only, dcache acks two cycles after the request
        clear_logs();
        dly = 2;
        stb2dcache_addr = 32'h10; stb2dcache_wdata = 32'hDEAD_BEEF; stb2dcache_sel_byte = 4'hF;
        stb2dcache_req = 1'b1; stb2dcache_w_en = 1'b1; stb2dcache_empty = 1'b0;
        run(8);
        chk("store_ngrant", grants.size(), 1);
        chk("store_kind", (grants.size() > 0) ? grants[0] : -1, 1);
        chk("store_ack_cnt", n_stb_ack, 1);
        chk("store_idle", arb2dcache_req, 1'b0);

        // Load only, fixed read data
        clear_logs();
        dly = 1; rd_fix = 1'b1;
        lsudbus2arb_addr = 32'h20; lsudbus2arb_req = 1'b1;
        run(6);
        rd_fix = 1'b0;
        chk("load_ngrant", grants.size(), 1);
        chk("load_kind", (grants.size() > 0) ? grants[0] : -1, 0);
        chk("load_ack_cnt", n_ld_ack, 1);

        // Contention: both sources keep a request outstanding back to back
        clear_logs();
        dly = 0; ld_cont = 1'b1; st_cont = 1'b1;
        lsudbus2arb_addr = $urandom; lsudbus2arb_req = 1'b1;
        stb2dcache_addr = $urandom; stb2dcache_wdata = $urandom; stb2dcache_sel_byte = 4'h3;
        stb2dcache_req = 1'b1; stb2dcache_w_en = 1'b1; stb2dcache_empty = 1'b0;
        for (int i = 0; i < 100 && grants.size() < 10; i++) cycle();
        chk("cont_ngrant", (grants.size() >= 10), 1'b1);
        for (int i = 0; i < 10; i++) begin
`ifdef STB_LOAD_ORDER_EN
            exp_g = 1;
`else
            exp_g = ((i % 5) == 4) ? 1 : 0;
`endif
            got_g = (i < grants.size()) ? grants[i] : -1;
            chk($sformatf("cont_grant%0d", i), got_g, exp_g);
        end
        ld_cont = 1'b0; st_cont = 1'b0;
        for (int i = 0; i < 60 && (lsudbus2arb_req || stb2dcache_req); i++) cycle();
        chk("cont_drained", {lsudbus2arb_req, stb2dcache_req}, 2'b00);
        run(2);

        // Spurious ack in IDLE
        clear_logs();
        spur_force = 1'b1;
        run(4);
        spur_force = 1'b0;
        run(1);
        chk("spur_ngrant", grants.size(), 0);
        chk("spur_acks", n_stb_ack + n_ld_ack, 0);

        // Reset asserted mid-store, then the store is re-issued
        dly = 3;
        stb2dcache_addr = 32'h44; stb2dcache_wdata = 32'hCAFE_F00D; stb2dcache_sel_byte = 4'h6;
        stb2dcache_req = 1'b1; stb2dcache_w_en = 1'b1; stb2dcache_empty = 1'b0;
        run(2);
        chk("rst_pre_req", arb2dcache_req, 1'b1);
        #2 rst_n = 1'b0;
        stb2dcache_req = 1'b0; stb2dcache_w_en = 1'b0;
        dcache2arb_ack = 1'b0;
        #1;
        chk_all_zero("rstmid");
        model_reset();
        prev_req = 1'b0; dly_cnt = 0;
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        clear_logs();
        stb2dcache_req = 1'b1; stb2dcache_w_en = 1'b1;
        run(8);
        chk("rst_re_ngrant", grants.size(), 1);
        chk("rst_re_ack", n_stb_ack, 1);

        // Store pending with buffer not empty, load waiting alongside
        clear_logs();
        dly = 1;
        stb2dcache_addr = 32'h80; stb2dcache_wdata = 32'h0BAD_CAFE; stb2dcache_sel_byte = 4'h1;
        stb2dcache_req = 1'b1; stb2dcache_w_en = 1'b1; stb2dcache_empty = 1'b0;
        lsudbus2arb_addr = 32'h90; lsudbus2arb_req = 1'b1;
        run(12);
        chk("order_ngrant", grants.size(), 2);
`ifdef STB_LOAD_ORDER_EN
        chk("order_first", (grants.size() > 0) ? grants[0] : -1, 1);
        chk("order_second", (grants.size() > 1) ? grants[1] : -1, 0);
`else
        chk("order_first", (grants.size() > 0) ? grants[0] : -1, 0);
        chk("order_second", (grants.size() > 1) ? grants[1] : -1, 1);
`endif

        // Randomized traffic with variable dcache latency and spurious acks
        ld_rand = 1'b1; st_rand = 1'b1; spur = 1'b1; rand_dly = 1'b1;
        run(400);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
